// File: rtl/mem_sweep_checker.sv
// Sweeps a simple-dual-port BRAM against an LFSR pattern and writes every word read back to itself; start->done takes DEPTH_MEM+2 cycles.
// There is no backpressure: start is ignored while busy. Optional fill pass (+DEPTH_MEM+1 cycles) is built under MEM_SWEEP_FILL_EN.
module mem_sweep_checker #(
  parameter int WID_MEM    = 1,
  parameter int DEPTH_MEM  = 65536,
  parameter int AW         = 16,
  parameter int GUARD_ADDR = DEPTH_MEM - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef MEM_SWEEP_FILL_EN
  input  logic               fill,
`endif
  input  logic [31:0]        seed,
  output logic [31:0]        raddr,
  output logic [31:0]        waddr,
  output logic [WID_MEM-1:0] din,
  input  logic [WID_MEM-1:0] dout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [31:0]        err_count,
  output logic               first_err_valid,
  output logic [AW-1:0]      first_err_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);
  localparam logic [AW-1:0] GUARD     = AW'(GUARD_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [AW-1:0]       r_raddr;
  logic [AW-1:0]       r_rd_q;
  logic                r_wb_valid;
  logic                r_cmp_en;
  logic [31:0]         r_lfsr;
  logic [31:0]         r_err_count;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic                r_first_err_valid;
  logic [AW-1:0]       r_first_err_addr;

  logic [31:0]         w_seed;
  logic                w_mismatch;
  logic                w_fill_act;
  logic [AW-1:0]       w_fill_addr;
  logic [AW-1:0]       w_waddr;
  logic [WID_MEM-1:0]  w_din;

`ifdef MEM_SWEEP_FILL_EN
  logic [31:0]         r_seed;
  logic [AW-1:0]       r_fill_cnt;

  assign w_fill_act  = (r_state == S_FILL);
  assign w_fill_addr = r_fill_cnt;
`else
  assign w_fill_act  = 1'b0;
  assign w_fill_addr = '0;
`endif

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  assign w_seed     = (seed == 32'd0) ? 32'd1 : seed;
  assign w_mismatch = r_cmp_en && (dout != r_lfsr[WID_MEM-1:0]) && (r_rd_q != GUARD);

  // The BRAM writes every clock, so an idle write port must point at the guard word.
  always_comb begin
    w_waddr = GUARD;
    w_din   = '0;
    if (w_fill_act) begin
      w_waddr = w_fill_addr;
      w_din   = r_lfsr[WID_MEM-1:0];
    end else if (r_wb_valid) begin
      w_waddr = r_rd_q;
      w_din   = dout;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state           <= S_IDLE;
      r_raddr           <= '0;
      r_rd_q            <= '0;
      r_wb_valid        <= 1'b0;
      r_cmp_en          <= 1'b0;
      r_lfsr            <= 32'd1;
      r_err_count       <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_first_err_valid <= 1'b0;
      r_first_err_addr  <= '0;
`ifdef MEM_SWEEP_FILL_EN
      r_seed            <= 32'd1;
      r_fill_cnt        <= '0;
`endif
    end else begin
      r_rd_q     <= r_raddr;
      r_wb_valid <= 1'b1;
      r_done     <= 1'b0;
      // Data for an address issued in SWEEP returns one cycle later.
      r_cmp_en   <= (r_state == S_SWEEP);

      if (r_cmp_en) begin
        r_lfsr <= lfsr_next(r_lfsr);
      end
      if (w_mismatch) begin
        if (r_err_count != 32'hFFFF_FFFF) begin
          r_err_count <= r_err_count + 32'd1;
        end
        if (!r_first_err_valid) begin
          r_first_err_valid <= 1'b1;
          r_first_err_addr  <= r_rd_q;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_lfsr            <= w_seed;
            r_err_count       <= '0;
            r_first_err_valid <= 1'b0;
            r_pass            <= 1'b0;
            r_busy            <= 1'b1;
            r_raddr           <= '0;
`ifdef MEM_SWEEP_FILL_EN
            r_seed            <= w_seed;
            r_fill_cnt        <= '0;
            r_state           <= fill ? S_FILL : S_SWEEP;
`else
            r_state           <= S_SWEEP;
`endif
          end
        end
`ifdef MEM_SWEEP_FILL_EN
        S_FILL: begin
          r_lfsr     <= lfsr_next(r_lfsr);
          r_fill_cnt <= r_fill_cnt + AW'(1);
          if (r_fill_cnt == LAST_ADDR) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_lfsr  <= r_seed;
          r_state <= S_SWEEP;
        end
`endif
        S_SWEEP: begin
          if (r_raddr == LAST_ADDR) begin
            r_state <= S_DRAIN;
          end else begin
            r_raddr <= r_raddr + AW'(1);
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_pass  <= (r_err_count == 32'd0);
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign raddr           = 32'(r_raddr);
  assign waddr           = 32'(w_waddr);
  assign din             = w_din;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign first_err_valid = r_first_err_valid;
  assign first_err_addr  = r_first_err_addr;

endmodule

// File: tb/tb_mem_sweep_checker.sv
// Directed bench for mem_sweep_checker on a 16x1 BRAM model with a preload port.
module tb_mem_sweep_checker;

  localparam int W = 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [31:0]   seed;
  logic [31:0]   raddr;
  logic [31:0]   waddr;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          busy;
  logic          done;
  logic          pass;
  logic [31:0]   err_count;
  logic          first_err_valid;
  logic [3:0]    first_err_addr;
`ifdef MEM_SWEEP_FILL_EN
  logic          fill;
`endif

  logic          poke_en;
  logic [3:0]    poke_addr;
  logic [W-1:0]  poke_dat;
  logic [W-1:0]  mem [0:15];
  logic [W-1:0]  exp_mem [0:15];

  int n_checks;
  int n_fail;

  mem_sweep_checker #(
    .WID_MEM(W), .DEPTH_MEM(16), .AW(4), .GUARD_ADDR(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
`ifdef MEM_SWEEP_FILL_EN
    .fill(fill),
`endif
    .seed(seed),
    .raddr(raddr),
    .waddr(waddr),
    .din(din),
    .dout(dout),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .first_err_valid(first_err_valid),
    .first_err_addr(first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-old-data BRAM; the poke port overrides the DUT write and bypasses to a same-address read.
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_dat;
    else         mem[waddr[3:0]] <= din;
    if (poke_en && poke_addr == raddr[3:0]) dout <= poke_dat;
    else                                    dout <= mem[raddr[3:0]];
  end

  function automatic logic [W-1:0] pat(input logic [31:0] sd, input int k);
    logic [31:0] s;
    s = (sd == 32'd0) ? 32'd1 : sd;
    for (int i = 0; i < k; i++) s = {s[30:0], ^(s & 32'h8020_0003)};
    return s[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [W-1:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_dat = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic preload(input logic [31:0] sd, input logic [15:0] flip);
    for (int a = 0; a < 16; a++) begin
      exp_mem[a] = pat(sd, a) ^ W'(flip[a]);
      poke(4'(a), exp_mem[a]);
    end
  endtask

  task automatic check_mem(input string name, input int last);
    int bad;
    bad = 0;
    for (int a = 0; a <= last; a++) if (mem[a] !== exp_mem[a]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic run_sweep(input logic [31:0] sd, input int pulse_at, output int lat,
                           output int ndone, output logic busy_early, output logic pass_early);
    lat = -1; ndone = 0; busy_early = 1'b0; pass_early = 1'b1;
    @(negedge clk);
    seed = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      start = (c == pulse_at);
      if (c == 1) begin busy_early = busy; pass_early = pass; end
      if (done) begin ndone++; if (lat < 0) lat = c; end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] seed;
    logic [15:0] flip;
    int          exp_err;
    logic        exp_vld;
    logic [3:0]  exp_addr;
    logic        exp_pass;
  } vec_t;

  vec_t vecs [6];
  int   lat, nd;
  logic be, pe;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b0; start = 1'b0; seed = 32'd0; poke_en = 1'b0; poke_addr = '0; poke_dat = '0;
`ifdef MEM_SWEEP_FILL_EN
    fill = 1'b0;
`endif

    vecs[0] = '{32'hACE1, 16'h0000, 0, 1'b0, 4'd0, 1'b1};
    vecs[1] = '{32'hACE1, 16'h0020, 1, 1'b1, 4'd5, 1'b0};
    vecs[2] = '{32'hACE1, 16'h8000, 0, 1'b0, 4'd0, 1'b1};
    vecs[3] = '{32'hACE1, 16'h0208, 2, 1'b1, 4'd3, 1'b0};
    vecs[4] = '{32'hACE1, 16'h7FFF, 15, 1'b1, 4'd0, 1'b0};
    // Sweep with seed 1 over the 0xACE1 image: expectations come from the reference pattern.
    vecs[5] = '{32'h0001, 16'h0000, 0, 1'b0, 4'd0, 1'b1};
    for (int a = 14; a >= 0; a--) begin
      if (pat(32'hACE1, a) != pat(32'h1, a)) begin
        vecs[5].exp_err++; vecs[5].exp_vld = 1'b1; vecs[5].exp_addr = 4'(a);
      end
    end
    vecs[5].exp_pass = (vecs[5].exp_err == 0);

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_first_err_valid", first_err_valid, 0);
    chk("rst_first_err_addr", first_err_addr, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_waddr", waddr, 15);
    chk("rst_din", din, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_waddr_hi", waddr[31:4], 0);

    for (int v = 0; v < 6; v++) begin
      preload(32'hACE1, vecs[v].flip);
      run_sweep(vecs[v].seed, 0, lat, nd, be, pe);
      chk($sformatf("v%0d_latency", v), lat, 18);
      chk($sformatf("v%0d_done_count", v), nd, 1);
      chk($sformatf("v%0d_busy_after_start", v), be, 1);
      chk($sformatf("v%0d_pass_cleared", v), pe, 0);
      chk($sformatf("v%0d_busy_end", v), busy, 0);
      chk($sformatf("v%0d_pass", v), pass, vecs[v].exp_pass);
      chk($sformatf("v%0d_err_count", v), err_count, vecs[v].exp_err);
      chk($sformatf("v%0d_first_err_valid", v), first_err_valid, vecs[v].exp_vld);
      if (vecs[v].exp_vld) chk($sformatf("v%0d_first_err_addr", v), first_err_addr, vecs[v].exp_addr);
      chk($sformatf("v%0d_raddr_hi", v), raddr[31:4], 0);
      check_mem($sformatf("v%0d_mem_intact", v), 15);
    end

    // Seed 0 behaves as seed 1; a start pulse mid-sweep is ignored.
    preload(32'hACE1, 16'h0000);
    run_sweep(32'h0, 5, lat, nd, be, pe);
    chk("seed0_latency", lat, 18);
    chk("seed0_done_count", nd, 1);
    chk("seed0_err_count", err_count, vecs[5].exp_err);
    chk("seed0_pass", pass, vecs[5].exp_pass);
    chk("seed0_first_err_valid", first_err_valid, vecs[5].exp_vld);
    if (vecs[5].exp_vld) chk("seed0_first_err_addr", first_err_addr, vecs[5].exp_addr);

    // Reset mid-sweep at address 7.
    preload(32'hACE1, 16'h0020);
    @(negedge clk); seed = 32'hACE1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 30 && raddr != 32'd7; i++) begin @(posedge clk); #1; end
    chk("abort_reach_addr7", raddr, 7);
    chk("abort_err_seen", first_err_valid, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    chk("abort_err_count", err_count, 0);
    chk("abort_first_err_valid", first_err_valid, 0);
    chk("abort_first_err_addr", first_err_addr, 0);
    chk("abort_raddr", raddr, 0);
    chk("abort_waddr", waddr, 15);
    chk("abort_din", din, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_mem("abort_mem_intact", 14);
    exp_mem[5] = pat(32'hACE1, 5);
    poke(4'd5, exp_mem[5]);
    run_sweep(32'hACE1, 0, lat, nd, be, pe);
    chk("resume_latency", lat, 18);
    chk("resume_pass", pass, 1);
    chk("resume_err_count", err_count, 0);

`ifdef MEM_SWEEP_FILL_EN
    for (int a = 0; a < 16; a++) poke(4'(a), '0);
    fill = 1'b1;
    run_sweep(32'h1234, 0, lat, nd, be, pe);
    fill = 1'b0;
    chk("fill_latency", lat, 35);
    chk("fill_done_count", nd, 1);
    chk("fill_pass", pass, 1);
    chk("fill_err_count", err_count, 0);
    for (int a = 0; a < 16; a++) exp_mem[a] = pat(32'h1234, a);
    check_mem("fill_mem_pattern", 15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sweep_checker.md
Name: mem_sweep_checker

Overview:
- Readback verifier that sits in front of the single-clock simple-dual-port BRAM `memory` block and owns all four of its address/data ports: `raddr`, `waddr`, `din` and `dout`.
- On `start` it sweeps every address, compares `dout` against a pseudo-random expected pattern, and reports the mismatch count and the first failing address.
- The BRAM writes on every clock and has no write enable, so the checker writes each word it reads back into the same address. This keeps the contents intact across idle periods and sweeps.

Parameters:
- `WID_MEM`, 1: data width, 1..32.
- `DEPTH_MEM`, 65536: number of words; power of two.
- `AW`, 16: address width, equal to log2(`DEPTH_MEM`).
- `GUARD_ADDR`, `DEPTH_MEM`-1: sacrificial address. It absorbs writes that carry no valid data and is never compared.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; honoured only in `IDLE`.
- `seed`  in  32  LFSR seed, sampled on an accepted `start`; 0 is replaced by 1.
- `raddr`  out  32  BRAM read address; upper bits are zero.
- `waddr`  out  32  BRAM write address; upper bits are zero.
- `din`  out  `WID_MEM`  BRAM write data.
- `dout`  in  `WID_MEM`  BRAM read data, valid one cycle after `raddr`.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `pass`  out  1  high when the last sweep had zero mismatches; held until the next `start`.
- `err_count`  out  32  mismatches in the last sweep; saturates at 0xFFFFFFFF.
- `first_err_valid`  out  1  high when at least one mismatch has been recorded.
- `first_err_addr`  out  `AW`  address of the first mismatch.

Behaviour:
- Reset (`reset`=0), asynchronous:
  - State goes to `IDLE`; `raddr`=0; `waddr`=`GUARD_ADDR`; `din`=0.
  - `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_valid`=0, `first_err_addr`=0.
  - Internal `wb_valid`=0.
- Write-back rule, applied in every state:
  - `rd_q` is the registered copy of `raddr`; `wb_valid` is high when a read was issued on the previous edge while out of reset.
  - When `wb_valid`=1: `waddr`=`rd_q` and `din`=`dout` (combinational pass-through). This rewrites the word just read with its own value.
  - When `wb_valid`=0: `waddr`=`GUARD_ADDR` and `din`=0.
- States:
  - `IDLE`: `raddr` holds its last value and write-back continues. On `start`: load the LFSR with `seed`, clear `err_count`, `first_err_valid` and `pass`, set `busy`, set `raddr`=0, and go to `SWEEP`.
  - `SWEEP`: each cycle `raddr` increments by 1. After issuing `DEPTH_MEM`-1, go to `DRAIN`.
  - `DRAIN`: one cycle for the final read; then go to `DONE`.
  - `DONE`: pulse `done`, drop `busy`, set `pass`=(`err_count`==0), and return to `IDLE`.
- Compare stage (active in `SWEEP` and `DRAIN`):
  - The compare on the cycle after address A was issued checks `dout` against `lfsr[WID_MEM-1:0]`, then steps the LFSR one position.
  - The LFSR is a 32-bit Fibonacci LFSR, taps x^32+x^22+x^2+x+1, shifting left with the new bit entering bit 0.
  - The LFSR steps for every address, including `GUARD_ADDR`.
  - A mismatch at A != `GUARD_ADDR` increments `err_count`, with saturation.
  - On the first such mismatch: set `first_err_valid`=1 and `first_err_addr`=A.
- Latency: `start` accepted at edge N gives `done`=1 in cycle N+`DEPTH_MEM`+2.
- `start` while `busy` is ignored.
- Reset mid-sweep aborts the sweep. All status clears. `GUARD_ADDR` may be written with 0; every other address is preserved.

Optional Feature:
- Macro `MEM_SWEEP_FILL_EN`.
- When defined, adds input port `fill` (1 bit), sampled with `start`. If `fill`=1, a `FILL` state runs before `SWEEP`:
  - `FILL` lasts `DEPTH_MEM` cycles.
  - Each cycle it writes `waddr`=k, `din`=`lfsr[WID_MEM-1:0]` for k=0..`DEPTH_MEM`-1, then steps the LFSR.
  - During `FILL`, `raddr` stays 0 and write-back is suppressed.
  - The LFSR then reloads `seed` and `SWEEP` follows.
  - Latency grows by `DEPTH_MEM`+1 cycles.
- When undefined: there is no `fill` port, no `FILL` state, and the block is verify-only.

Test Plan:
- `DEPTH_MEM`=16, `WID_MEM`=1; memory preloaded with the LFSR pattern for seed=0xACE1; `start` with seed 0xACE1 -> `done` at +18 cycles, `pass`=1, `err_count`=0, `first_err_valid`=0, contents unchanged.
- Same preload, but address 5 flipped -> `err_count`=1, `first_err_addr`=5, `pass`=0; address 5 still holds the flipped value after the sweep (write-back preserves it).
- Flip at `GUARD_ADDR`=15 only -> `err_count`=0, `pass`=1.
- `start` with seed=0 -> results identical to seed=1; `start` pulsed again mid-sweep -> ignored, a single `done`.
- `reset` asserted at sweep address 7 -> all outputs at reset values immediately; addresses 0..14 unchanged; a new `start` completes with `pass`=1.
- `MEM_SWEEP_FILL_EN` defined, all-zero memory, `fill`=1, seed=0x1234 -> `done` at +35 cycles, `pass`=1, memory holds the seed-0x1234 pattern.
